// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: UART receiver with a run-time frame format (5..DATA_WIDTH data bits,
// none/odd/even parity, 1/2 stop bits), 16x oversampling and 3-sample majority vote.
module uart_rx_cfg #(
  parameter int DATA_WIDTH    = 9,
  parameter int DIVIDER_WIDTH = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            rx_i,
  input  logic [DIVIDER_WIDTH-1:0]        clk_divider_i,
  input  logic [$clog2(DATA_WIDTH+1)-1:0] data_bits_i,
  input  logic                            parity_odd_i,
  input  logic                            parity_even_i,
  input  logic                            two_stop_i,
  output logic [DATA_WIDTH-1:0]           m_tdata_o,
  output logic                            m_tvalid_o,
  input  logic                            m_tready_i,
  output logic [2:0]                      m_tuser_o,
  output logic                            overrun_o,
  output logic                            busy_o
);

  localparam int BW = $clog2(DATA_WIDTH+1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_WAIT   = 3'd5
  } uart_state_e;

  function automatic logic [BW-1:0] clamp_bits(input logic [BW-1:0] n);
    if (n > BW'(DATA_WIDTH)) return BW'(DATA_WIDTH);
    if (n < BW'(5))          return BW'(5);
    return n;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  uart_state_e              state_q, state_d;
  logic                     rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_e_q, rx_e_d;
  logic [DIVIDER_WIDTH-1:0] div_cnt_q, div_cnt_d;
  logic [3:0]               tick_cnt_q, tick_cnt_d;
  logic                     samp7_q, samp7_d, samp8_q, samp8_d;
  logic [BW-1:0]            bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]    shreg_q, shreg_d;
  logic [BW-1:0]            nbits_q, nbits_d;
  logic                     par_en_q, par_en_d, par_odd_q, par_odd_d;
  logic                     two_stop_q, two_stop_d, stop_cnt_q, stop_cnt_d;
  logic                     par_err_q, par_err_d, par_zero_q, par_zero_d;
  logic [DATA_WIDTH-1:0]    tdata_q, tdata_d;
  logic [2:0]               tuser_q, tuser_d;
  logic                     tvalid_q, tvalid_d, overrun_q, overrun_d;

  logic                     fall, tick, decide, bit_val, exp_par;
  logic                     done, ferr, brk;
  logic [DIVIDER_WIDTH-1:0] div_load;

  assign fall     = rx_e_q & ~rx_s2_q;
  assign tick     = (state_q != S_IDLE) && (div_cnt_q == '0);
  assign decide   = tick && (tick_cnt_q == 4'd9);
  assign bit_val  = majority3(samp7_q, samp8_q, rx_s2_q);
  assign div_load = (clk_divider_i <= DIVIDER_WIDTH'(1)) ? '0
                                                         : clk_divider_i - DIVIDER_WIDTH'(1);
  assign exp_par  = par_odd_q ? ~^shreg_q : ^shreg_q;

  always_comb begin
    rx_s1_d    = rx_i;
    rx_s2_d    = rx_s1_q;
    rx_e_d     = rx_s2_q;
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    tick_cnt_d = tick_cnt_q;
    samp7_d    = samp7_q;
    samp8_d    = samp8_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    nbits_d    = nbits_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    two_stop_d = two_stop_q;
    stop_cnt_d = stop_cnt_q;
    par_err_d  = par_err_q;
    par_zero_d = par_zero_q;
    tdata_d    = tdata_q;
    tuser_d    = tuser_q;
    tvalid_d   = tvalid_q;
    overrun_d  = 1'b0;
    done       = 1'b0;
    ferr       = 1'b0;
    brk        = 1'b0;

    // Oversample tick generator: frozen in IDLE, free-running for the whole frame
    if (state_q == S_IDLE) begin
      div_cnt_d  = '0;
      tick_cnt_d = '0;
    end else if (tick) begin
      div_cnt_d  = div_load;
      tick_cnt_d = tick_cnt_q + 4'd1;
    end else begin
      div_cnt_d  = div_cnt_q - DIVIDER_WIDTH'(1);
    end

    if (tick && tick_cnt_q == 4'd7) samp7_d = rx_s2_q;
    if (tick && tick_cnt_q == 4'd8) samp8_d = rx_s2_q;

    unique case (state_q)
      S_IDLE: begin
        if (fall) begin
          // The edge cycle itself is tick 0
          state_d    = S_START;
          div_cnt_d  = div_load;
          tick_cnt_d = 4'd1;
          nbits_d    = clamp_bits(data_bits_i);
          par_en_d   = parity_odd_i | parity_even_i;
          par_odd_d  = parity_odd_i;
          two_stop_d = two_stop_i;
          stop_cnt_d = 1'b0;
          bit_cnt_d  = '0;
          shreg_d    = '0;
          par_err_d  = 1'b0;
          par_zero_d = 1'b1;
        end
      end
      S_START: begin
        if (decide) state_d = bit_val ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (decide) begin
          for (int i = 0; i < DATA_WIDTH; i++) begin
            if (BW'(i) == bit_cnt_q) shreg_d[i] = bit_val;
          end
          if (bit_cnt_q == nbits_q - BW'(1)) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      S_PARITY: begin
        if (decide) begin
          par_err_d  = (bit_val != exp_par);
          par_zero_d = ~bit_val;
          state_d    = S_STOP;
        end
      end
      S_STOP: begin
        if (decide) begin
          if (!bit_val) begin
            done = 1'b1;
            ferr = 1'b1;
            brk  = (shreg_q == '0) && par_zero_q && !stop_cnt_q;
          end else if (two_stop_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            done = 1'b1;
          end
          if (done) state_d = rx_s2_q ? S_IDLE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (rx_s2_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Output holding register; a frame arriving while one is still held is dropped
    if (tvalid_q && m_tready_i) tvalid_d = 1'b0;
    if (done) begin
      if (!tvalid_q || m_tready_i) begin
        tdata_d  = shreg_q;
        tuser_d  = {brk, ferr, par_err_q};
        tvalid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_e_q     <= 1'b1;
      div_cnt_q  <= '0;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      tdata_q    <= '0;
      tuser_q    <= '0;
      tvalid_q   <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_s1_q    <= rx_s1_d;
      rx_s2_q    <= rx_s2_d;
      rx_e_q     <= rx_e_d;
      div_cnt_q  <= div_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tdata_q    <= tdata_d;
      tuser_q    <= tuser_d;
      tvalid_q   <= tvalid_d;
      overrun_q  <= overrun_d;
    end
  end

  // Frame datapath and latched format: always (re)loaded before use
  always_ff @(posedge clk_i) begin
    samp7_q    <= samp7_d;
    samp8_q    <= samp8_d;
    shreg_q    <= shreg_d;
    nbits_q    <= nbits_d;
    par_en_q   <= par_en_d;
    par_odd_q  <= par_odd_d;
    two_stop_q <= two_stop_d;
    par_err_q  <= par_err_d;
    par_zero_q <= par_zero_d;
  end

  assign m_tdata_o  = tdata_q;
  assign m_tuser_o  = tuser_q;
  assign m_tvalid_o = tvalid_q;
  assign overrun_o  = overrun_q;
  assign busy_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed and randomized frames for uart_rx_cfg, checked against expectations
// computed from frame contents and format.
module tb_uart_rx_cfg;
  localparam int DW  = 9;
  localparam int DVW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_line;
  logic [DVW-1:0] div;
  logic [3:0]    data_bits;
  logic          par_odd, par_even, two_stop;
  logic          ready;
  logic [DW-1:0] m_tdata_o;
  logic          m_tvalid_o;
  logic [2:0]    m_tuser_o;
  logic          overrun_o;
  logic          busy_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  uart_rx_cfg #(.DATA_WIDTH(DW), .DIVIDER_WIDTH(DVW)) dut (
    .clk_i(clk), .rst_i(rst), .rx_i(rx_line), .clk_divider_i(div),
    .data_bits_i(data_bits), .parity_odd_i(par_odd), .parity_even_i(par_even),
    .two_stop_i(two_stop), .m_tdata_o(m_tdata_o), .m_tvalid_o(m_tvalid_o),
    .m_tready_i(ready), .m_tuser_o(m_tuser_o), .overrun_o(overrun_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // Observed transfers, overrun pulses and m_tvalid_o rising edges
  logic [11:0] rxq[$];
  int   ovr_cnt = 0;
  int   rise_cnt = 0;
  int   last_rise = -1;
  logic vld_prev = 1'b0;
  always @(negedge clk) begin
    if (m_tvalid_o === 1'b1 && ready === 1'b1) rxq.push_back({m_tuser_o, m_tdata_o});
    if (overrun_o === 1'b1) ovr_cnt++;
    if (m_tvalid_o === 1'b1 && !vld_prev) begin
      rise_cnt++;
      last_rise = cyc;
    end
    vld_prev = (m_tvalid_o === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int eff_bits(input int n);
    if (n > DW) return DW;
    if (n < 5) return 5;
    return n;
  endfunction

  function automatic int eff_div(input logic [DVW-1:0] d);
    return (d <= 1) ? 1 : int'(d);
  endfunction

  // pmode: 0 none, 1 odd, 2 even. noise_bit: frame bit index (0 = start) whose
  // tick-8 sample is inverted, or -1.
  task automatic send_frame(input logic [8:0] data, input int nb_in, input int pmode,
                            input bit two, input bit flip, input int noise_bit,
                            output int t0);
    bit bits[$];
    int nb, bt, ed;
    bit p, v;
    nb = eff_bits(nb_in);
    ed = eff_div(div);
    bt = 16 * ed;
    data_bits = 4'(nb_in);
    par_odd   = (pmode == 1);
    par_even  = (pmode == 2);
    two_stop  = two;
    bits = {};
    bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) bits.push_back(data[i]);
    if (pmode != 0) begin
      p = (pmode == 1);
      for (int i = 0; i < nb; i++) p ^= data[i];
      bits.push_back(p ^ flip);
    end
    bits.push_back(1'b1);
    if (two) bits.push_back(1'b1);
    t0 = cyc;
    for (int c = 0; c < bits.size() * bt; c++) begin
      v = bits[c / bt];
      if (noise_bit >= 0 && c >= noise_bit * bt + 8 * ed && c < noise_bit * bt + 9 * ed) v = ~v;
      rx_line = v;
      // Format changes mid-frame must not affect the frame in flight
      if (c == bt) begin
        data_bits = 4'($urandom);
        par_odd   = 1'($urandom);
        par_even  = 1'($urandom);
        two_stop  = 1'($urandom);
      end
      step(1);
    end
    rx_line = 1'b1;
  endtask

  task automatic expect_frame(input string tag, input logic [8:0] ed, input logic [2:0] eu);
    int w;
    logic [11:0] f;
    w = 0;
    while (rxq.size() == 0 && w < 3000) begin
      step(1);
      w++;
    end
    check({tag, "_rcv"}, (rxq.size() != 0), 1);
    if (rxq.size() != 0) begin
      f = rxq.pop_front();
      check({tag, "_data"}, f[8:0], ed);
      check({tag, "_user"}, f[11:9], eu);
    end
  endtask

  initial begin
    int t0, r0, o0, nb, pm;
    logic [8:0] d;
    bit two, flip;

    rst = 1'b1; rx_line = 1'b1; ready = 1'b1; div = 4;
    data_bits = 4'd8; par_odd = 1'b0; par_even = 1'b0; two_stop = 1'b0;
    step(4);
    check("rst_tvalid", m_tvalid_o, 0);
    check("rst_tdata", m_tdata_o, 0);
    check("rst_tuser", m_tuser_o, 0);
    check("rst_overrun", overrun_o, 0);
    check("rst_busy", busy_o, 0);
    rst = 1'b0;
    step(5);

    // 8N1 0xA5 with latency check: 2 sync + 1 edge cycles, then tick 9 of bit 9
    r0 = rise_cnt;
    send_frame(9'h0A5, 8, 0, 1'b0, 1'b0, -1, t0);
    expect_frame("8n1_a5", 9'h0A5, 3'b000);
    check("8n1_latency", last_rise, t0 + 3 + (16 * 9 + 9) * 4);
    check("8n1_pulses", rise_cnt - r0, 1);
    check("8n1_vld_low", m_tvalid_o, 0);
    step(20);

    // Back-to-back 7O2 then 9E1, clean and with the parity bit inverted
    for (int k = 0; k < 2; k++) begin
      send_frame(9'h055, 7, 1, 1'b1, k[0], -1, t0);
      send_frame(9'h1C3, 9, 2, 1'b0, k[0], -1, t0);
      expect_frame("7o2", 9'h055, {2'b00, k[0]});
      expect_frame("9e1", 9'h1C3, {2'b00, k[0]});
      step(20);
    end

    // False start: low for 5 ticks only
    data_bits = 4'd8; par_odd = 1'b0; par_even = 1'b0; two_stop = 1'b0;
    rx_line = 1'b0;
    step(5 * 4);
    rx_line = 1'b1;
    step(60);
    check("glitch_busy", busy_o, 0);
    check("glitch_nofrm", rxq.size(), 0);

    // Single-tick noise at tick 8 of data bit 3
    send_frame(9'h096, 8, 0, 1'b0, 1'b0, 4, t0);
    expect_frame("noise", 9'h096, 3'b000);
    step(20);

    // Break: line low for 20 bit times
    data_bits = 4'd8; par_odd = 1'b0; par_even = 1'b0; two_stop = 1'b0;
    rx_line = 1'b0;
    step(20 * 16 * 4);
    check("brk_busy_wait", busy_o, 1);
    rx_line = 1'b1;
    step(100);
    check("brk_count", rxq.size(), 1);
    expect_frame("brk", 9'h000, 3'b110);
    check("brk_idle", busy_o, 0);
    send_frame(9'h05A, 8, 0, 1'b0, 1'b0, -1, t0);
    expect_frame("after_brk", 9'h05A, 3'b000);
    step(20);

    // Overrun with the consumer stalled
    ready = 1'b0;
    o0 = ovr_cnt;
    send_frame(9'h011, 8, 0, 1'b0, 1'b0, -1, t0);
    step(10);
    send_frame(9'h022, 8, 0, 1'b0, 1'b0, -1, t0);
    step(10);
    check("ovr_pulses", ovr_cnt - o0, 1);
    check("ovr_vld", m_tvalid_o, 1);
    check("ovr_held", m_tdata_o, 9'h011);
    check("ovr_none_xfer", rxq.size(), 0);
    ready = 1'b1;
    step(3);
    check("ovr_one_xfer", rxq.size(), 1);
    expect_frame("ovr", 9'h011, 3'b000);
    step(200);
    check("ovr_no_more", rxq.size(), 0);

    // Reset during the data bits of 0x3C
    data_bits = 4'd8; par_odd = 1'b0; par_even = 1'b0; two_stop = 1'b0;
    rx_line = 1'b0; step(64);
    rx_line = 1'b0; step(64);
    rx_line = 1'b0; step(64);
    rx_line = 1'b1; step(20);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    check("rstmid_busy", busy_o, 0);
    check("rstmid_vld", m_tvalid_o, 0);
    step(800);
    check("rstmid_nofrm", rxq.size(), 0);
    send_frame(9'h03C, 8, 0, 1'b0, 1'b0, -1, t0);
    expect_frame("rstmid_next", 9'h03C, 3'b000);
    step(20);

    // Randomized formats, dividers (including 0 and 1), noise and parity errors
    for (int k = 0; k < 8; k++) begin
      d    = 9'($urandom);
      nb   = int'($urandom_range(0, 15));
      pm   = int'($urandom_range(0, 2));
      two  = 1'($urandom);
      flip = (pm != 0) && ($urandom_range(0, 1) == 1);
      div  = DVW'($urandom_range(0, 5));
      send_frame(d, nb, pm, two, flip, int'($urandom_range(1, 5)), t0);
      expect_frame("rand", d & 9'((1 << eff_bits(nb)) - 1), {2'b00, flip});
      step(10);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver, the next generation of the UART datapath. It supports a run-time selectable frame format (5..DATA_WIDTH data bits, none/odd/even parity, 1 or 2 stop bits) and 16x oversampling with 3-sample majority vote. It also detects false starts, and reports parity, framing, break and overrun conditions. It sits between the pad-side rx line and the RX FIFO of the UART register block, and is fed by the control and clock-divider registers.

## Interface
Parameters:
- DATA_WIDTH, 9: maximum data bits per frame. Legal range 5..9.
- DIVIDER_WIDTH, 32: width of the oversample divider.

Ports:
- clk_i  in  1: single clock.
- rst_i  in  1: synchronous, active-high reset.
- rx_i  in  1: asynchronous serial line, idle high.
- clk_divider_i  in  DIVIDER_WIDTH: clk_i cycles per oversample tick (clk_freq/(16*baud)). Values 0 and 1 both mean a tick every cycle.
- data_bits_i  in  $clog2(DATA_WIDTH+1): data bits per frame. Values above DATA_WIDTH clamp to DATA_WIDTH; values below 5 clamp to 5.
- parity_odd_i  in  1: odd parity enable. Takes priority over parity_even_i.
- parity_even_i  in  1: even parity enable.
- two_stop_i  in  1: 1 = two stop bits.
- m_tdata_o  out  DATA_WIDTH: received data, LSB = first bit, zero-extended above data_bits.
- m_tvalid_o  out  1: frame available.
- m_tready_i  in  1: consumer accepts.
- m_tuser_o  out  3: {break, frame_err, parity_err} for the held frame.
- overrun_o  out  1: one-cycle pulse when a completed frame is dropped.
- busy_o  out  1: high in any state other than IDLE.

## Operation
- rx_i passes through a 2-FF synchronizer, then a 1-FF edge register. The falling edge is detected on the synchronized value.
- Tick generator: a counter loads clk_divider_i-1 and emits a tick on reaching 0. It is held reset in IDLE and restarts when a falling edge is detected, so tick 0 aligns with the edge.
- Bit timing: 16 ticks per bit, numbered 0..15. The bit value is the majority of the samples taken at ticks 7, 8 and 9. The decision is made at tick 9.
- Config latching: data_bits, parity mode and stop count are latched on IDLE->START. Changes mid-frame have no effect until the next frame.
- States (the uart_state_e encoding is reused):
  - IDLE: on falling edge -> START.
  - START: at tick 9, majority 1 -> IDLE (false start, no output); majority 0 -> DATA.
  - DATA: shift LSB first. After data_bits bits -> PARITY if parity is enabled, else STOP.
  - PARITY: compare the sampled bit against the expected value. Odd: expected = ~^data. Even: expected = ^data. A mismatch sets parity_err.
  - STOP: sample 1 or 2 stop bits. Any stop bit sampled 0 sets frame_err and ends STOP at that bit. Frame completion is then processed (see next bullet). Next state is WAIT if the line is low, else IDLE.
  - WAIT: stay until the synchronized line is high, then -> IDLE. No new start is detected in WAIT.
- Break: all data bits 0, parity bit 0 (if enabled) and first stop bit 0 sets break=1 and frame_err=1.
- Output register:
  - On completion with m_tvalid_o=0 or a handshake in the same cycle, load m_tdata_o/m_tuser_o and set m_tvalid_o.
  - Otherwise the new frame is discarded, overrun_o pulses, and the held frame is unchanged.
  - m_tvalid_o clears when m_tvalid_o and m_tready_i are both high, unless a new frame loads in that same cycle.
  - m_tdata_o/m_tuser_o are stable while m_tvalid_o=1 and m_tready_i=0.

## Timing
- Reset values: state IDLE, m_tvalid_o=0, m_tdata_o=0, m_tuser_o=0, overrun_o=0, busy_o=0, tick counter 0, synchronizers 1.
- Reset mid-frame aborts the frame with no output. The first frame after reset release is received normally.
- Input latency: 2 clk_i from a rx_i edge to its synchronized value.
- Output latency: m_tvalid_o rises 1 clk_i after the tick-9 decision of the final stop bit, or of the first failing stop bit.
- After completion with rx high, the next frame's falling edge is accepted from the following cycle, i.e. during the last half of the stop bit.
- Handshake: transfer occurs when m_tvalid_o & m_tready_i at a clk_i rising edge. m_tvalid_o never drops without a handshake.
- busy_o follows state combinationally from the registered state.

## Test plan
- 8N1, clk_divider_i=4, send 0xA5 with m_tready_i=1 -> m_tdata_o=0x0A5, m_tuser_o=3'b000, one m_tvalid_o pulse 1 clk after the stop-bit tick 9.
- 7O2 then 9E1 back-to-back, send 0x55 then 0x1C3 -> 0x055 then 0x1C3, no errors. Repeat with the parity bit flipped -> m_tuser_o=3'b001.
- 8N1 glitch: rx low for 5 ticks -> no output, state back to IDLE, busy_o=0. Single-tick noise at tick 8 of a data bit -> majority gives the correct byte.
- 8N1, line held low for 20 bit times -> one frame with data 0x00, m_tuser_o=3'b110. No further frames until the line goes high and a new start arrives.
- 8N1, m_tready_i=0, send 0x11 then 0x22 -> held frame stays 0x11, overrun_o pulses once at the second completion. Raising m_tready_i then transfers 0x11 only.
- 8N1, assert rst_i during DATA of 0x3C -> no output. The next frame 0x3C is received correctly.
